prio_enc_stream: RTL and testbench
==================================

PRIO_ENC_STREAM -- requirements
Module: prio_enc_stream

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning number of request bits (2..64).
REQ-002 The block SHALL have parameter W, default $clog2(N), meaning index width (derived; not overridden).
REQ-003 The block SHALL have parameter CW, default 16, meaning zero-vector counter width.
REQ-004 clk  input  1  meaning single clock; all state updates on rising edge.
REQ-005 rst  input  1  meaning reset, asynchronous and active-high.
REQ-006 in_x  input  N  meaning request vector; bit i is request i.
REQ-007 in_valid  input  1  meaning in_x is presented.
REQ-008 in_ready  output  1  meaning block can accept in_x this cycle.
REQ-009 out_y  output  W  meaning encoded index of the winning request.
REQ-010 out_any  output  1  meaning at least one request bit was set in the encoded vector.
REQ-011 out_valid  output  1  meaning out_y/out_any hold a result.
REQ-012 out_ready  input  1  meaning consumer takes the result this cycle.
REQ-013 zero_cnt  output  CW  meaning count of accepted all-zero vectors.

Function
REQ-014 The accept condition SHALL be in_valid && in_ready; the output handshake condition SHALL be out_valid && out_ready.
REQ-015 in_ready SHALL equal !out_valid || out_ready (combinational; single output register, no skid buffer).
REQ-016 The output register SHALL be a 2-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 Transitions SHALL be: EMPTY->FULL on accept; FULL->EMPTY on output handshake without accept; FULL->FULL on simultaneous output handshake and accept, with the new result loaded.
REQ-018 The latency from accept to out_valid SHALL be exactly 1 cycle; the sustained throughput SHALL be 1 vector/cycle while out_ready=1.
REQ-019 Fixed-priority mode SHALL make the highest set bit of in_x win; out_y = its index.
REQ-020 For an all-zero in_x, out_any SHALL be 0 and out_y SHALL be 0, and the result SHALL still be delivered with out_valid=1.
REQ-021 out_y and out_any SHALL hold stable while FULL and not handshaken.
REQ-022 zero_cnt SHALL increment by 1 on each accepted all-zero vector and saturate at 2^CW-1 (no wrap).
REQ-023 When no accept occurs, the registered result and zero_cnt SHALL be unchanged; in_x is ignored when in_valid=0.

Reset
REQ-024 While rst=1, the block SHALL force state EMPTY, out_valid=0, out_y=0, out_any=0, zero_cnt=0, and rotation pointer=N-1, asynchronously.
REQ-025 A reset asserted mid-transfer SHALL discard the held result; no partial output is presented after release.
REQ-026 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-027 With macro PRIO_ENC_RR_EN defined, the block SHALL use round-robin priority: the search starts at pointer ptr and descends with wrap (ptr, ptr-1, ..., 0, N-1, ..., ptr+1).
REQ-028 With PRIO_ENC_RR_EN defined, on each accept with out_any=1, ptr SHALL become (winner-1) mod N; all-zero vectors leave ptr unchanged.
REQ-029 With PRIO_ENC_RR_EN defined, ptr SHALL be a W-bit register; for non-power-of-2 N, the wrap uses N-1, not 2^W-1.
REQ-030 Without PRIO_ENC_RR_EN, no pointer register SHALL exist and behaviour SHALL be REQ-019 only.

Structure
REQ-031 Package prio_enc_pkg SHALL hold the FSM state enum (EMPTY, FULL) and the zero_cnt saturate constant helper.
REQ-032 Sub-module prio_enc_core SHALL be the combinational N-bit priority search taking (vector, start pointer) and returning (index, any); prio_enc_stream instantiates one.

Verification
REQ-033 N=8, reset then accept 8'b00000000 -> next cycle out_valid=1, out_any=0, out_y=0, zero_cnt=1.
REQ-034 N=8, fixed mode, accept 8'b01010110 -> out_y=6, out_any=1; accept 8'b10000001 -> out_y=7.
REQ-035 out_ready=0 with FULL, in_valid=1 -> in_ready=0, out_y stable for 5 cycles; then out_ready=1 for one cycle -> new vector loaded the same cycle, out_valid stays 1.
REQ-036 CW=2, accept 5 all-zero vectors -> zero_cnt sequence 1,2,3,3,3.
REQ-037 PRIO_ENC_RR_EN, N=8, accept 8'b11111111 four times back-to-back -> out_y = 7,6,5,4; then 8'b10000001 -> out_y=0, ptr=7.
REQ-038 Assert rst while FULL with out_ready=0 -> out_valid=0 immediately (same cycle, asynchronously), zero_cnt=0; randomized 1000-vector run against a fixed/rr reference model -> 0 mismatches.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared types and constants for the streaming priority encoder.
package prio_enc_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Largest value a cw-bit up-counter may reach before it holds.
  function automatic logic [63:0] zc_sat_max(input int unsigned cw);
    return (cw >= 64) ? {64{1'b1}} : ((64'd1 << cw) - 64'd1);
  endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational N-bit priority search: scans down from i_start with wrap and
// reports the first set bit found.
module prio_enc_core #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  input  logic [W-1:0] i_start,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  // w_pos[k] is the k-th position visited: i_start, i_start-1, ..., wrapping at N-1.
  logic [W-1:0] w_pos [N];

  for (genvar k = 0; k < N; k++) begin : g_pos
    assign w_pos[k] = (int'(i_start) >= k) ? W'(int'(i_start) - k)
                                           : W'(int'(i_start) + N - k);
  end

  // Walk from the last candidate back to the first so the earliest hit wins.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_vec[w_pos[k]]) begin
        o_idx = w_pos[k];
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_enc_stream.sv
// Streaming priority encoder with a single valid/ready output register.
// Define PRIO_ENC_RR_EN for round-robin priority; default is highest-bit-wins.
module prio_enc_stream
  import prio_enc_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = $clog2(N),
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_x,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_y,
  output logic          out_any,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] zero_cnt
);

  localparam logic [CW-1:0] ZC_MAX = CW'(zc_sat_max(CW));

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_y;
  logic          r_any;
  logic [CW-1:0] r_zero_cnt;
  logic          w_accept;
  logic          w_out_hs;
  logic [W-1:0]  w_start;
  logic [W-1:0]  w_idx;
  logic          w_any;

  assign out_valid = (r_state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_out_hs  = out_valid && out_ready;
  assign out_y     = r_y;
  assign out_any   = r_any;
  assign zero_cnt  = r_zero_cnt;

`ifdef PRIO_ENC_RR_EN
  logic [W-1:0] r_ptr;

  // Next search begins just below the last winner; empty vectors keep the pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= W'(N - 1);
    end else if (w_accept && w_any) begin
      r_ptr <= (w_idx == '0) ? W'(N - 1) : w_idx - W'(1);
    end
  end

  assign w_start = r_ptr;
`else
  assign w_start = W'(N - 1);
`endif

  prio_enc_core #(
    .N (N),
    .W (W)
  ) u_core (
    .i_vec   (in_x),
    .i_start (w_start),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_accept) w_state_nxt = FULL;
      FULL:    if (w_out_hs && !w_accept) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_y        <= '0;
      r_any      <= 1'b0;
      r_zero_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_y   <= w_idx;
        r_any <= w_any;
        if (!w_any && (r_zero_cnt != ZC_MAX)) begin
          r_zero_cnt <= r_zero_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_prio_enc_stream.sv
// Bench for prio_enc_stream: directed vectors plus a random run, checked each
// cycle against a behavioural model; a CW=2 twin exercises counter saturation.
module tb_prio_enc_stream;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] in_x = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;

  logic         in_ready, out_any, out_valid;
  logic [W-1:0] out_y;
  logic [15:0]  zc16;
  logic         s_in_ready, s_out_any, s_out_valid;
  logic [W-1:0] s_out_y;
  logic [1:0]   zc2;

  int n_tests = 0;
  int n_fail  = 0;

  prio_enc_stream #(.N(N), .CW(16)) u_dut (
    .clk(clk), .rst(rst), .in_x(in_x), .in_valid(in_valid), .in_ready(in_ready),
    .out_y(out_y), .out_any(out_any), .out_valid(out_valid), .out_ready(out_ready),
    .zero_cnt(zc16)
  );

  prio_enc_stream #(.N(N), .CW(2)) u_sat (
    .clk(clk), .rst(rst), .in_x(in_x), .in_valid(in_valid), .in_ready(s_in_ready),
    .out_y(s_out_y), .out_any(s_out_any), .out_valid(s_out_valid), .out_ready(out_ready),
    .zero_cnt(zc2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an occupancy flag, the held result, two counters, a pointer.
  bit       m_full;
  int       m_y;
  bit       m_any;
  int       m_zc16;
  int       m_zc2;
  int       m_ptr;

  // Visit p, p-1, ..., 0, N-1, ... and return the first set position (or -1).
  function automatic int winner(input logic [N-1:0] x, input int p);
    for (int k = 0; k < N; k++) begin
      if (x[(p - k + N) % N]) return (p - k + N) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_full <= 1'b0;
      m_y    <= 0;
      m_any  <= 1'b0;
      m_zc16 <= 0;
      m_zc2  <= 0;
      m_ptr  <= N - 1;
    end else if (in_valid && (!m_full || out_ready)) begin
      int w;
      w = winner(in_x, m_ptr);
      m_full <= 1'b1;
      m_any  <= (w >= 0);
      m_y    <= (w >= 0) ? w : 0;
      if (w < 0) begin
        if (m_zc16 < 65535) m_zc16 <= m_zc16 + 1;
        if (m_zc2 < 3)      m_zc2  <= m_zc2 + 1;
      end
`ifdef PRIO_ENC_RR_EN
      if (w >= 0) m_ptr <= (w + N - 1) % N;
`endif
    end else if (out_ready) begin
      m_full <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(m_full));
    chk("in_ready", 64'(in_ready), 64'(!m_full || out_ready));
    chk("zero_cnt", 64'(zc16), 64'(m_zc16));
    chk("sat_zero_cnt", 64'(zc2), 64'(m_zc2));
    chk("sat_out_valid", 64'(s_out_valid), 64'(m_full));
    chk("sat_in_ready", 64'(s_in_ready), 64'(!m_full || out_ready));
    if (m_full) begin
      chk("out_y", 64'(out_y), 64'(m_y));
      chk("out_any", 64'(out_any), 64'(m_any));
      chk("sat_out_y", 64'(s_out_y), 64'(m_y));
      chk("sat_out_any", 64'(s_out_any), 64'(m_any));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] x);
    in_valid  = 1'b1;
    in_x      = x;
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_zero_cnt", 64'(zc16), 64'd0);

    send(8'b00000000);
    chk("zero_vec_valid", 64'(out_valid), 64'd1);
    chk("zero_vec_any", 64'(out_any), 64'd0);
    chk("zero_vec_y", 64'(out_y), 64'd0);
    chk("zero_vec_cnt", 64'(zc16), 64'd1);

`ifdef PRIO_ENC_RR_EN
    send(8'b11111111); chk("rr_ff_1", 64'(out_y), 64'd7);
    send(8'b11111111); chk("rr_ff_2", 64'(out_y), 64'd6);
    send(8'b11111111); chk("rr_ff_3", 64'(out_y), 64'd5);
    send(8'b11111111); chk("rr_ff_4", 64'(out_y), 64'd4);
    send(8'b10000001); chk("rr_81", 64'(out_y), 64'd0);
    send(8'b11111111); chk("rr_ptr_wrap", 64'(out_y), 64'd7);
`else
    send(8'b01010110);
    chk("fix_56_y", 64'(out_y), 64'd6);
    chk("fix_56_any", 64'(out_any), 64'd1);
    send(8'b10000001); chk("fix_81_y", 64'(out_y), 64'd7);
`endif

    // Backpressure: result 7 must hold while a new vector waits.
    in_valid  = 1'b1;
    in_x      = 8'b00010000;
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_y", 64'(out_y), 64'd7);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("reload_valid", 64'(out_valid), 64'd1);
    chk("reload_y", 64'(out_y), 64'd4);

    // Asynchronous reset while FULL and stalled.
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_cnt", 64'(zc16), 64'd0);
    chk("async_rst_y", 64'(out_y), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    // Saturation of the 2-bit counter: 1,2,3,3,3.
    send(8'b0); chk("sat_1", 64'(zc2), 64'd1);
    send(8'b0); chk("sat_2", 64'(zc2), 64'd2);
    send(8'b0); chk("sat_3", 64'(zc2), 64'd3);
    send(8'b0); chk("sat_4", 64'(zc2), 64'd3);
    send(8'b0); chk("sat_5", 64'(zc2), 64'd3);
    chk("wide_cnt_5", 64'(zc16), 64'd5);

    for (int i = 0; i < 1000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_x      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
      if (i == 500) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
